matrix_mult_unit: RTL and testbench
===================================

MATRIX_MULT_UNIT -- requirements
Module: matrix_mult_unit

Interface
REQ-001 The block SHALL have a single clock and a reset that is asynchronous and active-high.
REQ-002 DATA_W  default 8  operand element width; only 8 is supported.
REQ-003 clk  in  1  rising-edge clock shared with the register file.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  single-cycle request to multiply the current register-file snapshot.
REQ-006 ReadDataA0..ReadDataA3  in  8 each  matrix A in row-major order: [[A0,A1],[A2,A3]], taken from registers 0..3.
REQ-007 ReadDataB0..ReadDataB3  in  8 each  matrix B in row-major order: [[B0,B1],[B2,B3]], taken from registers 4..7.
REQ-008 busy  out  1  high while an operation is in progress.
REQ-009 is_matrix_mult  out  1  one-cycle pulse; C is valid and is written back to registers 0..3.
REQ-010 C  out  32  result, packed {C11,C10,C01,C00}, with C00 in bits [7:0].

Function
REQ-011 The block SHALL use a state machine with states IDLE, CALC and DONE; it leaves reset in IDLE.
REQ-012 In IDLE, a start sampled high SHALL latch all eight operands into internal registers, clear the accumulator and step counter, and move to CALC.
REQ-013 Operands SHALL be taken only at that start edge; input changes afterwards SHALL NOT affect the result.
REQ-014 CALC SHALL perform exactly one 8x8 multiply-accumulate per cycle over 8 steps, with step counter values 0..7, in this order:
 - steps 0-1: C00 = A0*B0 + A1*B2
 - steps 2-3: C01 = A0*B1 + A1*B3
 - steps 4-5: C10 = A2*B0 + A3*B2
 - steps 6-7: C11 = A2*B1 + A3*B3
REQ-015 The accumulator SHALL be 17 bits wide; it SHALL clear at each even step, and the element SHALL be stored into C at each odd step.
REQ-016 Element reduction to 8 bits SHALL be modulo 256 (take bits [7:0]), unless configured otherwise (REQ-024).
REQ-017 After step 7 the block SHALL enter DONE; in DONE, is_matrix_mult SHALL be high for exactly one cycle, and the next state is IDLE.
REQ-018 Latency: is_matrix_mult SHALL be high in the 9th cycle after the start-sampling edge; a new start is accepted in the cycle after DONE, giving a throughput of 1 result per 10 cycles.
REQ-019 busy SHALL be high in CALC and DONE and low in IDLE.
REQ-020 start while busy is high (including the DONE cycle) SHALL be ignored and SHALL NOT be queued.
REQ-021 C SHALL hold its last value in IDLE until the next operation overwrites it element by element; C is guaranteed consistent only while is_matrix_mult is high.

Reset
REQ-022 On reset, including mid-operation, the block SHALL:
 - go to IDLE
 - set busy=0, is_matrix_mult=0, C=0
 - clear the operand latches, accumulator and step counter
 - discard any partial result without producing a pulse.
REQ-023 The first start SHALL be accepted on the first rising clk edge after reset is released.

Configuration
REQ-024 With MATRIX_MULT_SAT_EN defined, each element SHALL saturate to 8'hFF whenever the 17-bit sum exceeds 255; without it, elements SHALL wrap modulo 256. Latency and handshake are the same in both builds.

Verification
REQ-025 Reset, then start using the register-file reset contents (A=0,1,2,3; B=4,5,6,7) -> is_matrix_mult is high 9 cycles later, C=32'h1F1A0706.
REQ-026 All operands 8'hFF -> C=32'h02020202 without MATRIX_MULT_SAT_EN; C=32'hFFFFFFFF with it.
REQ-027 Pulse start again at cycles 3 and 9 after the accepted start, and change operands at cycle 2 -> exactly one is_matrix_mult pulse, and the result matches the operands latched at the start edge.
REQ-028 Assert reset at step 4 -> busy=0 and C=0 immediately; no pulse occurs; a following start with A=1,0,0,1 and B=9,8,7,6 yields C=32'h06070809.
REQ-029 Two back-to-back operations with start held high continuously -> pulses occur 10 cycles apart, and the second result is correct.

Source files
------------

// File: rtl/matrix_mult_unit_if.sv
// Operand/result bundle between the register file and matrix_mult_unit.
interface matrix_mult_unit_if #(
    parameter int DATA_W = 8
);
    logic              start;
    logic [DATA_W-1:0] ReadDataA0;
    logic [DATA_W-1:0] ReadDataA1;
    logic [DATA_W-1:0] ReadDataA2;
    logic [DATA_W-1:0] ReadDataA3;
    logic [DATA_W-1:0] ReadDataB0;
    logic [DATA_W-1:0] ReadDataB1;
    logic [DATA_W-1:0] ReadDataB2;
    logic [DATA_W-1:0] ReadDataB3;
    logic              busy;
    logic              is_matrix_mult;
    logic [31:0]       C;

    modport master (
        output start,
        output ReadDataA0, ReadDataA1, ReadDataA2, ReadDataA3,
        output ReadDataB0, ReadDataB1, ReadDataB2, ReadDataB3,
        input  busy, is_matrix_mult, C
    );

    modport slave (
        input  start,
        input  ReadDataA0, ReadDataA1, ReadDataA2, ReadDataA3,
        input  ReadDataB0, ReadDataB1, ReadDataB2, ReadDataB3,
        output busy, is_matrix_mult, C
    );
endinterface

// File: rtl/matrix_mult_unit.sv
// 2x2 x 2x2 matrix multiply, one 8x8 MAC per cycle over 8 steps.
// MATRIX_MULT_SAT_EN: saturate each element to 8'hFF instead of wrapping mod 256.
//   state | meaning
//   IDLE  | waiting for start, C holds last result
//   CALC  | steps 0..7, one MAC per cycle
//   DONE  | result valid, one-cycle is_matrix_mult pulse
module matrix_mult_unit #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    matrix_mult_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [DATA_W-1:0] r_a [4];
    logic [DATA_W-1:0] r_b [4];
    logic [2:0]        r_step;
    logic [16:0]       r_acc;
    logic [31:0]       r_c;

    logic              w_load;
    logic              w_mac;
    logic [1:0]        w_a_idx;
    logic [1:0]        w_b_idx;
    logic [15:0]       w_prod;
    logic [16:0]       w_sum;
    logic [7:0]        w_elem_val;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_mac  = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_load = 1'b1;
                    w_next = CALC;
                end
            end
            CALC: begin
                w_mac = 1'b1;
                if (r_step == 3'd7) w_next = DONE;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // step = {row, col, k}: A[row][k] * B[k][col], element index {row, col}
    assign w_a_idx = {r_step[2], r_step[0]};
    assign w_b_idx = {r_step[0], r_step[1]};
    assign w_prod  = 16'(r_a[w_a_idx]) * 16'(r_b[w_b_idx]);
    assign w_sum   = r_step[0] ? (r_acc + 17'(w_prod)) : 17'(w_prod);

`ifdef MATRIX_MULT_SAT_EN
    assign w_elem_val = (w_sum > 17'd255) ? 8'hFF : w_sum[7:0];
`else
    assign w_elem_val = w_sum[7:0];
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                r_a[i] <= '0;
                r_b[i] <= '0;
            end
            r_step <= 3'd0;
            r_acc  <= 17'd0;
            r_c    <= 32'd0;
        end else if (w_load) begin
            r_a[0] <= bus.ReadDataA0;
            r_a[1] <= bus.ReadDataA1;
            r_a[2] <= bus.ReadDataA2;
            r_a[3] <= bus.ReadDataA3;
            r_b[0] <= bus.ReadDataB0;
            r_b[1] <= bus.ReadDataB1;
            r_b[2] <= bus.ReadDataB2;
            r_b[3] <= bus.ReadDataB3;
            r_step <= 3'd0;
            r_acc  <= 17'd0;
        end else if (w_mac) begin
            r_acc  <= w_sum;
            r_step <= r_step + 3'd1;
            if (r_step[0]) r_c[{r_step[2:1], 3'b000} +: 8] <= w_elem_val;
        end
    end

    assign bus.busy           = (r_state != IDLE);
    assign bus.is_matrix_mult = (r_state == DONE);
    assign bus.C              = r_c;
endmodule

// File: tb/tb_matrix_mult_unit.sv
// Scoreboard bench for matrix_mult_unit: stimulus pushes expected C, a negedge monitor pops on each pulse.
module tb_matrix_mult_unit;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    matrix_mult_unit_if ifc ();

    matrix_mult_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    int          n_tests    = 0;
    int          n_fail     = 0;
    int          cycle_no   = 0;
    int          pulse_cnt  = 0;
    int          last_pulse = 0;
    int          pulse_gap  = 0;
    logic [31:0] exp_q [$];

`ifdef MATRIX_MULT_SAT_EN
    localparam logic [31:0] EXP_ALL_FF = 32'hFFFFFFFF;
`else
    localparam logic [31:0] EXP_ALL_FF = 32'h02020202;
`endif

    always @(posedge clk) cycle_no <= cycle_no + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && ifc.is_matrix_mult) begin
            pulse_cnt++;
            pulse_gap  = cycle_no - last_pulse;
            last_pulse = cycle_no;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_pulse: got C=%h, expected no pulse", ifc.C);
            end else begin
                check("result_C", ifc.C, exp_q.pop_front());
                check("busy_in_done", 32'(ifc.busy), 32'd1);
            end
        end
    end

    task automatic set_ops(input logic [7:0] a0, a1, a2, a3, b0, b1, b2, b3);
        ifc.ReadDataA0 = a0; ifc.ReadDataA1 = a1; ifc.ReadDataA2 = a2; ifc.ReadDataA3 = a3;
        ifc.ReadDataB0 = b0; ifc.ReadDataB1 = b1; ifc.ReadDataB2 = b2; ifc.ReadDataB3 = b3;
    endtask

    // Called at a negedge while idle; returns at a negedge in the first idle cycle.
    task automatic run_op(input logic [31:0] exp, input string name);
        int cyc   = 0;
        bit found = 0;
        exp_q.push_back(exp);
        ifc.start = 1'b1;
        @(posedge clk);
        #1 ifc.start = 1'b0;
        while (cyc < 30 && !found) begin
            cyc++;
            @(negedge clk);
            if (ifc.is_matrix_mult) found = 1;
            else @(posedge clk);
        end
        check({name, "_latency"}, 32'(cyc), 32'd9);
        @(posedge clk);
        @(negedge clk);
        check({name, "_idle_after"}, 32'(ifc.busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int p0;
        reset     = 1'b1;
        ifc.start = 1'b0;
        set_ops(8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 32'(ifc.busy), 32'd0);
        check("reset_pulse", 32'(ifc.is_matrix_mult), 32'd0);
        check("reset_C", ifc.C, 32'd0);

        // start accepted on the very first edge after release
        reset = 1'b0;
        run_op(32'h1F1A0706, "regfile_reset");
        repeat (3) @(negedge clk);
        check("C_hold_idle", ifc.C, 32'h1F1A0706);

        set_ops(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        run_op(EXP_ALL_FF, "all_ff");

        // operands change and extra starts during the operation are ignored
        set_ops(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8);
        p0 = pulse_cnt;
        exp_q.push_back(32'h322B1613);
        ifc.start = 1'b1;
        @(posedge clk);
        #1 ifc.start = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 2) set_ops(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
            ifc.start = (c == 3 || c == 9);
        end
        ifc.start = 1'b0;
        repeat (10) @(negedge clk);
        check("ignored_starts_pulses", 32'(pulse_cnt - p0), 32'd1);
        check("ignored_starts_idle", 32'(ifc.busy), 32'd0);

        // reset during step 4
        set_ops(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8);
        p0 = pulse_cnt;
        ifc.start = 1'b1;
        @(posedge clk);
        #1 ifc.start = 1'b0;
        repeat (5) @(negedge clk);
        check("busy_mid_op", 32'(ifc.busy), 32'd1);
        reset = 1'b1;
        #1;
        check("midreset_busy", 32'(ifc.busy), 32'd0);
        check("midreset_C", ifc.C, 32'd0);
        check("midreset_pulse", 32'(ifc.is_matrix_mult), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        check("midreset_no_pulse", 32'(pulse_cnt - p0), 32'd0);
        set_ops(8'd1, 8'd0, 8'd0, 8'd1, 8'd9, 8'd8, 8'd7, 8'd6);
        run_op(32'h06070809, "after_reset");

        // start held high: two operations back to back
        set_ops(8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7);
        p0 = pulse_cnt;
        exp_q.push_back(32'h1F1A0706);
        exp_q.push_back(32'h06070809);
        ifc.start = 1'b1;
        @(posedge clk);
        #1 set_ops(8'd1, 8'd0, 8'd0, 8'd1, 8'd9, 8'd8, 8'd7, 8'd6);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            #1;
            if (pulse_cnt - p0 >= 2) break;
        end
        ifc.start = 1'b0;
        check("b2b_pulses", 32'(pulse_cnt - p0), 32'd2);
        check("b2b_gap", 32'(pulse_gap), 32'd10);
        repeat (15) @(negedge clk);
        check("b2b_no_extra", 32'(pulse_cnt - p0), 32'd2);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
